// File: rtl/uart_dbg_pkg.sv
// rtl/uart_dbg_pkg.sv - shared types and byte codes for the UART debug loader
package uart_dbg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_MASK  = 3'd3,
        ST_WRITE = 3'd4,
        ST_RESP  = 3'd5
    } state_t;

    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_H = 8'h48;
    localparam logic [7:0] CMD_G = 8'h47;

    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

endpackage

// File: rtl/uart_dbg_loader.sv
// rtl/uart_dbg_loader.sv - UART byte stream to debug-port memory writes, owns CPU reset
module uart_dbg_loader
    import uart_dbg_pkg::*;
#(
    parameter int unsigned WR_HOLD     = 4,
    parameter int unsigned TIMEOUT     = 100000,
    parameter int unsigned BOOT_HALTED = 1
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        cpu_n_reset,
    output logic        dbg_mem_op,
    output logic [3:0]  dbg_wren,
    output logic [31:0] dbg_adr,
    output logic [31:0] dbg_do,
    output logic        busy
);

    localparam logic CPU_N_RESET_INIT = (BOOT_HALTED == 0);

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] idle_cnt_q, idle_cnt_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic [3:0]  wren_q, wren_d;
    logic [7:0]  resp_q, resp_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        cpu_n_reset_q, cpu_n_reset_d;
    logic        mem_op_q, mem_op_d;
    logic [3:0]  dbg_wren_q, dbg_wren_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] do_q, do_d;
    logic        idle_expired;

    // Frame timeout fires once the gap since the last byte reaches TIMEOUT cycles.
    assign idle_expired = (idle_cnt_q == 32'(TIMEOUT - 1));

    // State register; reset drops any in-flight frame or write without a response.
    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            idle_cnt_q    <= '0;
            hold_cnt_q    <= '0;
            wren_q        <= '0;
            resp_q        <= '0;
            tx_data_q     <= '0;
            tx_valid_q    <= 1'b0;
            cpu_n_reset_q <= CPU_N_RESET_INIT;
            mem_op_q      <= 1'b0;
            dbg_wren_q    <= '0;
            adr_q         <= '0;
            do_q          <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            idle_cnt_q    <= idle_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            wren_q        <= wren_d;
            resp_q        <= resp_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            cpu_n_reset_q <= cpu_n_reset_d;
            mem_op_q      <= mem_op_d;
            dbg_wren_q    <= dbg_wren_d;
            adr_q         <= adr_d;
            do_q          <= do_d;
        end
    end

    // Frame decode, byte assembly, write window and response handshake.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        idle_cnt_d    = idle_cnt_q;
        hold_cnt_d    = hold_cnt_q;
        wren_d        = wren_q;
        resp_d        = resp_q;
        tx_data_d     = tx_data_q;
        tx_valid_d    = 1'b0;
        cpu_n_reset_d = cpu_n_reset_q;
        mem_op_d      = mem_op_q;
        dbg_wren_d    = dbg_wren_q;
        adr_d         = adr_q;
        do_d          = do_q;

        unique case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_W) begin
                        state_d    = ST_ADDR;
                        idx_d      = '0;
                        idle_cnt_d = '0;
                    end else if (rx_data == CMD_H) begin
                        cpu_n_reset_d = 1'b0;
                        resp_d        = ACK;
                        state_d       = ST_RESP;
                    end else if (rx_data == CMD_G) begin
                        cpu_n_reset_d = 1'b1;
                        resp_d        = ACK;
                        state_d       = ST_RESP;
                    end else begin
                        resp_d  = NAK;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_ADDR, ST_DATA, ST_MASK: begin
                if (rx_valid) begin
                    idle_cnt_d = '0;
                    if (state_q == ST_MASK) begin
                        wren_d = rx_data[3:0];
                        // A running CPU must never see the debug port take the bus.
                        if (!cpu_n_reset_q) begin
                            mem_op_d   = 1'b1;
                            dbg_wren_d = rx_data[3:0];
                            hold_cnt_d = '0;
                            state_d    = ST_WRITE;
                        end else begin
                            resp_d  = NAK;
                            state_d = ST_RESP;
                        end
                    end else begin
                        if (state_q == ST_ADDR) begin
                            adr_d[{idx_q, 3'b000} +: 8] = rx_data;
                        end else begin
                            do_d[{idx_q, 3'b000} +: 8] = rx_data;
                        end
                        idx_d = idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            state_d = (state_q == ST_ADDR) ? ST_DATA : ST_MASK;
                        end
                    end
                end else if (idle_expired) begin
                    resp_d  = NAK;
                    state_d = ST_RESP;
                end else begin
                    idle_cnt_d = idle_cnt_q + 32'd1;
                end
            end
            ST_WRITE: begin
                if (hold_cnt_q == 8'(WR_HOLD - 1)) begin
                    mem_op_d   = 1'b0;
                    dbg_wren_d = '0;
                    resp_d     = ACK;
                    state_d    = ST_RESP;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            ST_RESP: begin
                if (!tx_busy) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = resp_q;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign cpu_n_reset = cpu_n_reset_q;
    assign dbg_mem_op  = mem_op_q;
    assign dbg_wren    = dbg_wren_q;
    assign dbg_adr     = adr_q;
    assign dbg_do      = do_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_dbg_loader.sv
// tb/tb_uart_dbg_loader.sv - self-checking bench for uart_dbg_loader
module tb_uart_dbg_loader;

    localparam int WR_HOLD = 4;
    localparam int TIMEOUT = 64;

    logic        CLK = 1'b0;
    logic        RES = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        tx_busy = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        cpu_n_reset;
    logic        dbg_mem_op;
    logic [3:0]  dbg_wren;
    logic [31:0] dbg_adr;
    logic [31:0] dbg_do;
    logic        busy;

    uart_dbg_loader #(.WR_HOLD(WR_HOLD), .TIMEOUT(TIMEOUT), .BOOT_HALTED(1)) dut (
        .CLK(CLK), .RES(RES), .rx_data(rx_data), .rx_valid(rx_valid), .tx_busy(tx_busy),
        .tx_data(tx_data), .tx_valid(tx_valid), .cpu_n_reset(cpu_n_reset),
        .dbg_mem_op(dbg_mem_op), .dbg_wren(dbg_wren), .dbg_adr(dbg_adr), .dbg_do(dbg_do),
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Observed-traffic record, sampled on the falling edge.
    int          cyc = 0;
    int          tx_count = 0;
    logic [7:0]  tx_last = 8'h00;
    int          tx_cyc = 0;
    int          n_pulses = 0;
    int          pulse_len = 0;
    bit          in_pulse = 0;
    bit          unstable = 0;
    bit          illegal = 0;
    logic [31:0] p_adr = 0;
    logic [31:0] p_do = 0;
    logic [3:0]  p_wren = 0;
    int          last_byte_cyc = 0;

    always @(negedge CLK) begin
        if (dbg_mem_op) begin
            if (!in_pulse) begin
                in_pulse  = 1;
                pulse_len = 1;
                n_pulses++;
                p_adr  = dbg_adr;
                p_do   = dbg_do;
                p_wren = dbg_wren;
            end else begin
                pulse_len++;
                if (dbg_adr !== p_adr || dbg_do !== p_do || dbg_wren !== p_wren) unstable = 1;
            end
            if (cpu_n_reset) illegal = 1;
        end else begin
            in_pulse = 0;
        end
        if (tx_valid) begin
            tx_count++;
            tx_last = tx_data;
            tx_cyc  = cyc;
        end
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge CLK);
        rx_valid = 1'b0;
        last_byte_cyc = cyc;
    endtask

    task automatic send_w(input logic [31:0] a, input logic [31:0] d, input logic [7:0] m);
        send_byte(8'h57);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
        for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
        send_byte(m);
    endtask

    // Waits (bounded) for exactly one response strobe and checks its code.
    task automatic wait_resp(input string tag, input logic [7:0] code, input int start);
        for (int i = 0; i < 600 && tx_count == start; i++) @(negedge CLK);
        @(negedge CLK);
        chk({tag, "_resp_count"}, tx_count, start + 1);
        chk({tag, "_resp_code"}, {24'h0, tx_last}, {24'h0, code});
        chk({tag, "_idle"}, {31'h0, busy}, 32'h0);
    endtask

    // Reference: a W frame either writes (halted CPU) exactly once, or NAKs with no bus activity.
    task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [7:0] m, input bit halted);
        int p0, t0, mask_cyc;
        p0 = n_pulses;
        t0 = tx_count;
        send_w(a, d, m);
        mask_cyc = last_byte_cyc;
        if (halted) begin
            chk({tag, "_latency"}, {31'h0, dbg_mem_op}, 32'h1);
            wait_resp(tag, 8'h06, t0);
            chk({tag, "_pulses"}, n_pulses - p0, 1);
            chk({tag, "_hold"}, pulse_len, WR_HOLD);
            chk({tag, "_adr"}, p_adr, a);
            chk({tag, "_do"}, p_do, d);
            chk({tag, "_wren"}, {28'h0, p_wren}, {28'h0, m[3:0]});
            chk({tag, "_ack_late"}, {31'h0, (tx_cyc - mask_cyc) >= WR_HOLD}, 32'h1);
        end else begin
            wait_resp(tag, 8'h15, t0);
            chk({tag, "_nopulse"}, n_pulses - p0, 0);
        end
    endtask

    initial begin
        bit          halted;
        int          t0;
        logic [7:0]  b;
        logic [31:0] ra, rd;

        // Reset state
        RES = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rst_tx_valid", {31'h0, tx_valid}, 0);
        chk("rst_tx_data", {24'h0, tx_data}, 0);
        chk("rst_mem_op", {31'h0, dbg_mem_op}, 0);
        chk("rst_wren", {28'h0, dbg_wren}, 0);
        chk("rst_adr", dbg_adr, 0);
        chk("rst_do", dbg_do, 0);
        chk("rst_cpu", {31'h0, cpu_n_reset}, 0);
        chk("rst_busy", {31'h0, busy}, 0);
        RES = 1'b0;
        halted = 1;

        // Halt, then the reference program word
        t0 = tx_count;
        send_byte(8'h48);
        chk("h_cpu", {31'h0, cpu_n_reset}, 0);
        wait_resp("h", 8'h06, t0);
        do_write("w_prog", 32'h0002_0000, 32'h0320_0593, 8'h0F, halted);

        // Byte-lane writes
        do_write("w_b0", 32'h0000_000C, 32'h0000_0032, 8'h01, halted);
        do_write("w_b1", 32'h0000_000D, 32'h0000_3100, 8'h02, halted);
        do_write("w_m0", 32'h0000_0010, 32'hDEAD_BEEF, 8'hF0, halted);

        // Go: CPU runs, writes refused
        t0 = tx_count;
        send_byte(8'h47);
        chk("g_cpu", {31'h0, cpu_n_reset}, 1);
        wait_resp("g", 8'h06, t0);
        halted = 0;
        do_write("w_running", 32'h0000_0100, 32'h1234_5678, 8'h0F, halted);

        // Randomized command mix against the reference
        for (int it = 0; it < 24; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    t0 = tx_count;
                    send_byte(8'h48);
                    halted = 1;
                    wait_resp("rnd_h", 8'h06, t0);
                end
                1: begin
                    t0 = tx_count;
                    send_byte(8'h47);
                    halted = 0;
                    wait_resp("rnd_g", 8'h06, t0);
                end
                2: begin
                    do
                        b = 8'($urandom_range(0, 255));
                    while (b == 8'h57 || b == 8'h48 || b == 8'h47);
                    t0 = tx_count;
                    send_byte(b);
                    wait_resp("rnd_bad", 8'h15, t0);
                end
                default: begin
                    ra = $urandom;
                    rd = $urandom;
                    do_write("rnd_w", ra, rd, 8'($urandom_range(0, 255)), halted);
                end
            endcase
            chk("rnd_cpu", {31'h0, cpu_n_reset}, {31'h0, !halted});
        end

        // Inter-byte timeout
        t0 = tx_count;
        send_byte(8'h48);
        wait_resp("to_h", 8'h06, t0);
        halted = 1;
        t0 = tx_count;
        send_byte(8'h57);
        send_byte(8'h00);
        send_byte(8'h00);
        wait_resp("timeout", 8'h15, t0);
        chk("timeout_late", {31'h0, (tx_cyc - last_byte_cyc) >= TIMEOUT}, 32'h1);
        t0 = tx_count;
        send_byte(8'h48);
        wait_resp("after_to", 8'h06, t0);

        // Unknown byte while transmitter busy
        tx_busy = 1'b1;
        t0 = tx_count;
        send_byte(8'h5A);
        repeat (50) @(negedge CLK);
        chk("txbusy_hold", tx_count, t0);
        tx_busy = 1'b0;
        wait_resp("txbusy", 8'h15, t0);
        repeat (10) @(negedge CLK);
        chk("txbusy_single", tx_count, t0 + 1);

        // Reset in the second write cycle
        t0 = tx_count;
        send_w(32'h0000_0200, 32'hCAFE_F00D, 8'h0F);
        chk("res_w_start", {31'h0, dbg_mem_op}, 1);
        @(negedge CLK);
        RES = 1'b1;
        @(negedge CLK);
        RES = 1'b0;
        chk("res_mem_op", {31'h0, dbg_mem_op}, 0);
        chk("res_cpu", {31'h0, cpu_n_reset}, 0);
        chk("res_busy", {31'h0, busy}, 0);
        repeat (20) @(negedge CLK);
        chk("res_no_tx", tx_count, t0);

        chk("never_stable_violation", {31'h0, unstable}, 0);
        chk("never_op_while_running", {31'h0, illegal}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
